bcd_serial_adder: RTL and testbench

Digit-serial multi-digit packed-BCD adder that sits directly upstream of the single-digit BCD adder. It accepts two DIGITS-wide packed-BCD operands and a carry-in over a valid/ready handshake. It feeds one digit pair per cycle, least-significant first, through a single-digit BCD adder, with the inter-digit carry held in a register. It returns the packed-BCD sum and the final carry over a second valid/ready handshake.

---
 rtl/bcd_serial_adder_pkg.sv | 20 ++
 rtl/bcd_serial_adder_digit_add.sv | 32 +++
 rtl/bcd_serial_adder.sv | 136 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// ----------------------------------------------------------------------------
// bcd_serial_adder_pkg : shared constants and types for the serial BCD adder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bcd_serial_adder_pkg;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/bcd_serial_adder_digit_add.sv
// ----------------------------------------------------------------------------
// bcd_digit_add : combinational single-digit BCD adder with decimal carry
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  logic [4:0] w_t;

  always_comb begin
    w_t   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    digit = w_t[3:0];
    cout  = 1'b0;
    // Above nine, adding six wraps the binary nibble back into decimal range.
    if (w_t > 5'(BCD_MAX)) begin
      digit = w_t[3:0] + 4'(BCD_CORR);
      cout  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_adder.sv
// ----------------------------------------------------------------------------
// bcd_serial_adder : digit-serial packed-BCD adder, one digit pair per cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic              r_cout;
  logic              r_err;

  logic [W-1:0]      w_a_sh;
  logic [W-1:0]      w_b_sh;
  bcd_digit_t        w_digit;
  logic              w_carry;
  logic              w_last;
  logic              w_accept;
  logic              w_err;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign err       = r_err;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDXW'(DIGITS - 1));

  // Shifting rather than part-selecting keeps the mux in range for DIGITS=1.
  assign w_a_sh = r_a >> {r_idx, 2'b00};
  assign w_b_sh = r_b >> {r_idx, 2'b00};

  bcd_digit_add u_digit (
    .a     (w_a_sh[3:0]),
    .b     (w_b_sh[3:0]),
    .cin   (r_carry),
    .digit (w_digit),
    .cout  (w_carry)
  );

  always_comb begin
    w_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'(BCD_MAX) || b[4*i +: 4] > 4'(BCD_MAX)) begin
        w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ADD;
      ADD:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= w_err;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDXW'(i)) r_sum[4*i +: 4] <= w_digit;
          end
          r_carry <= w_carry;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_carry;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_bcd_serial_adder : randomized and directed checks against a digit model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_serial_adder;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          err;

  int checks   = 0;
  int failures = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: digit-by-digit decimal addition with the +6 correction rule.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mc, output logic [W-1:0] ms,
                                output logic mco, output logic me);
    int carry = mc;
    ms = '0;
    me = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      int ad = int'(ma[4*i +: 4]);
      int bd = int'(mb[4*i +: 4]);
      int t  = ad + bd + carry;
      if (ad > 9 || bd > 9) me = 1'b1;
      if (t > 9) begin
        ms[4*i +: 4] = 4'((t + 6) % 16);
        carry = 1;
      end else begin
        ms[4*i +: 4] = 4'(t);
        carry = 0;
      end
    end
    mco = (carry != 0);
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Issue one operation, check latency, hold back-pressure, then release.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                        input int hold, input logic [W-1:0] es, input logic eco,
                        input logic ee);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    a = oa; b = ob; cin = oc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    chk("in_ready_busy", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 3 * DIGITS + 4) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, DIGITS);
    chk("sum", sum, es);
    chk("cout", cout, eco);
    chk("err", err, ee);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_sum", {err, cout, sum}, {ee, eco, es});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_ready", in_ready, 1'b1);
    chk("post_valid", out_valid, 1'b0);
  endtask

  task automatic run_model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                           input logic oc, input int hold);
    logic [W-1:0] es;
    logic eco, ee;
    model(oa, ob, oc, es, eco, ee);
    run_op(oa, ob, oc, hold, es, eco, ee);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_outs", {err, cout, sum}, '0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 0, 16'h6912, 1'b0, 1'b0);
    run_op(16'h9999, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b1, 0, 16'h9999, 1'b1, 1'b0);
    run_op(16'h4821, 16'h3707, 1'b1, 5, 16'h8529, 1'b0, 1'b0);
    run_model(16'h12A4, 16'h0000, 1'b0, 1);
    run_op(16'h12A4, 16'h0000, 1'b0, 0, 16'h1304, 1'b0, 1'b1);

    // Reset in the middle of an addition.
    @(negedge clk);
    a = 16'h5555; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_outs", {cout, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0505, 16'h0505, 1'b0, 0, 16'h1010, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra, rb;
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 9) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
      run_model(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
